// File: rtl/instruction_phase_decoder.sv
// Free-running 4-phase sequencer producing one-hot FETCH/DECODE/EXECUTE/COMMIT strobes.
// Optional hold input enabled by defining INSTR_PHASE_STALL_EN.
module instruction_phase_decoder (
  input  logic       clk,
  input  logic       reset,
`ifdef INSTR_PHASE_STALL_EN
  input  logic       stall,
`endif
  output logic       fetch,
  output logic       decode,
  output logic       execute,
  output logic       commit,
  output logic [1:0] phase
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'b0001,
    S_DECODE  = 4'b0010,
    S_EXECUTE = 4'b0100,
    S_COMMIT  = 4'b1000
  } state_t;

  // Power-up value keeps the strobes defined before the first reset.
  state_t state_reg = S_FETCH;
  state_t state_next;
  logic   legal;
  logic   hold;

`ifdef INSTR_PHASE_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_next = S_FETCH;
    legal      = 1'b1;
    case (state_reg)
      S_FETCH:   state_next = S_DECODE;
      S_DECODE:  state_next = S_EXECUTE;
      S_EXECUTE: state_next = S_COMMIT;
      S_COMMIT:  state_next = S_FETCH;
      default: begin
        state_next = S_FETCH;
        legal      = 1'b0;
      end
    endcase
    // A stall only freezes a legal phase; corrupted state still recovers to FETCH.
    if (hold && legal)
      state_next = state_reg;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state_reg <= S_FETCH;
    else
      state_reg <= state_next;
  end

  assign fetch   = state_reg[0];
  assign decode  = state_reg[1];
  assign execute = state_reg[2];
  assign commit  = state_reg[3];

  always_comb begin
    phase = 2'd0;
    case (state_reg)
      S_FETCH:   phase = 2'd0;
      S_DECODE:  phase = 2'd1;
      S_EXECUTE: phase = 2'd2;
      S_COMMIT:  phase = 2'd3;
      default:   phase = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_instruction_phase_decoder.sv
// Directed bench for instruction_phase_decoder: power-up, reset, wrap, and (optionally) stall.
module tb_instruction_phase_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fetch, decode, execute, commit;
  logic [1:0] phase;
`ifdef INSTR_PHASE_STALL_EN
  logic       stall = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  instruction_phase_decoder dut (
    .clk     (clk),
    .reset   (reset),
`ifdef INSTR_PHASE_STALL_EN
    .stall   (stall),
`endif
    .fetch   (fetch),
    .decode  (decode),
    .execute (execute),
    .commit  (commit),
    .phase   (phase)
  );

  always #10 clk = ~clk;

  // Compare strobes and phase against the expected phase index.
  task automatic chk(input string tag, input int idx);
    logic [3:0] exp_vec;
    logic [3:0] obs_vec;
    logic [1:0] exp_ph;
    exp_vec = 4'b0001 << idx;
    exp_ph  = idx[1:0];
    obs_vec = {commit, execute, decode, fetch};
    total++;
    assert (obs_vec === exp_vec) else begin
      bad++;
      $error("FAIL %s strobes t=%0t observed=%b expected=%b", tag, $time, obs_vec, exp_vec);
    end
    total++;
    assert (phase === exp_ph) else begin
      bad++;
      $error("FAIL %s phase t=%0t observed=%0d expected=%0d", tag, $time, phase, exp_ph);
    end
    $display("t=%0t %s strobes=%b phase=%0d exp=%0d", $time, tag, obs_vec, phase, idx);
  endtask

  task automatic step(input string tag, input int idx);
    @(posedge clk);
    #5;
    chk(tag, idx);
  endtask

  initial begin
    int idx;
    #5;
    chk("powerup", 0);
    step("pu_e10", 1);
    step("pu_e30", 2);
    step("pu_e50", 3);
    #5;                  // t=60
    reset = 1'b1;
    step("rst_e70", 0);
    #5;                  // t=80
    reset = 1'b0;
    step("post_e90", 1);
    step("post_e110", 2);
    step("post_e130", 3);
    step("post_e150", 0);
    step("post_e170", 1);
    step("post_e190", 2);   // now in EXECUTE

    // Reset mid-instruction: abandon the cycle, no COMMIT pulse.
    reset = 1'b1;
    step("rst_in_exec", 0);
    reset = 1'b0;
    step("after_exec_rst", 1);

    // Reset held for three edges.
    reset = 1'b1;
    step("hold_rst1", 0);
    step("hold_rst2", 0);
    step("hold_rst3", 0);
    reset = 1'b0;
    step("hold_release", 1);

    // Ten full instruction cycles with a reference phase counter.
    idx = 1;
    for (int e = 0; e < 40; e++) begin
      idx = (idx + 1) % 4;
      step("run", idx);
      total++;
      assert ($countones({commit, execute, decode, fetch}) == 1) else begin
        bad++;
        $error("FAIL run_onehot t=%0t observed=%b expected=one-hot", $time,
               {commit, execute, decode, fetch});
      end
    end

`ifdef INSTR_PHASE_STALL_EN
    // Bring the sequencer to DECODE, then stall for two edges.
    reset = 1'b1;
    step("st_rst", 0);
    reset = 1'b0;
    step("st_decode", 1);
    stall = 1'b1;
    step("st_hold1", 1);
    step("st_hold2", 1);
    stall = 1'b0;
    step("st_resume", 2);
    // Reset wins over stall.
    stall = 1'b1;
    reset = 1'b1;
    step("st_rst_prec", 0);
    reset = 1'b0;
    step("st_hold_fetch", 0);
    stall = 1'b0;
    step("st_resume2", 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
